reaction_ctrl: RTL and testbench

//  Reaction-timer control FSMD, directly downstream of the random delay generator.
//  - On start it pulses delay_start to the delay block, then waits for delay_complete.
//  - It then lights the stimulus LED and counts reaction time in milliseconds until stop.
//  - Result is presented as 4 BCD digits for the 7-seg mux; also flags cheat (early stop)
//    and timeout.

---
 rtl/reaction_ctrl_if.sv | 33 +++
 rtl/reaction_ctrl.sv | 162 ++++++++++++++++
 tb/tb_reaction_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/reaction_ctrl_if.sv
// Handshake bundle between the reaction-timer controller and its surroundings
// (buttons, random delay generator, LED, 7-seg display mux).
// Handshake semantics: every input is a single-cycle pulse (no valid/ready
// back-pressure); the controller samples each on a rising clk edge and may
// ignore it depending on state. delay_start is a single-cycle registered
// pulse. All other outputs are registered levels.
interface reaction_ctrl_if;
  logic       clear;
  logic       start_btn;
  logic       stop_btn;
  logic       delay_complete;
  logic       delay_start;
  logic       led;
  logic [3:0] bcd3;
  logic [3:0] bcd2;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic       cheat;
  logic       timeout;
  logic [1:0] dbg_state;

  // Environment side: drives the button and delay pulses.
  modport master (
    output clear, start_btn, stop_btn, delay_complete,
    input  delay_start, led, bcd3, bcd2, bcd1, bcd0, cheat, timeout, dbg_state
  );

  // Controller side.
  modport slave (
    input  clear, start_btn, stop_btn, delay_complete,
    output delay_start, led, bcd3, bcd2, bcd1, bcd0, cheat, timeout, dbg_state
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer control FSMD: kicks the random delay generator, lights the
// stimulus LED once the delay elapses, counts reaction time in ms as 4 BCD
// digits, and flags early stops (cheat) and no-stop (timeout).
module reaction_ctrl #(
  parameter int CLK_PER_MS = 100000,
  parameter int MAX_MS     = 1000
) (
  input  logic              clk,
  input  logic              reset,
  reaction_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

  // Timeout value in BCD so it can be compared directly against the digits.
  localparam logic [15:0] MAX_BCD = {4'((MAX_MS / 1000) % 10),
                                     4'((MAX_MS / 100) % 10),
                                     4'((MAX_MS / 10) % 10),
                                     4'(MAX_MS % 10)};

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          cheat_q, cheat_d;
  logic          timeout_q, timeout_d;
  logic          led_q, led_d;
  logic          delay_start_q, delay_start_d;

  logic          ms_tick;
  logic [15:0]   bcd_inc;
  logic          inc_is_max;

  // Decimal increment with carry across the four digits.
  function automatic logic [15:0] bcd_add1(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign ms_tick    = (presc_q == PRESC_LAST);
  assign bcd_inc    = bcd_add1(bcd_q);
  assign inc_is_max = (bcd_inc == MAX_BCD);

  // Register all state and datapath values; reset aborts any trial at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      bcd_q         <= '0;
      cheat_q       <= 1'b0;
      timeout_q     <= 1'b0;
      led_q         <= 1'b0;
      delay_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      bcd_q         <= bcd_d;
      cheat_q       <= cheat_d;
      timeout_q     <= timeout_d;
      led_q         <= led_d;
      delay_start_q <= delay_start_d;
    end
  end

  // Next-state and next-datapath logic; clear overrides every other input.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    bcd_d         = bcd_q;
    cheat_d       = cheat_q;
    timeout_d     = timeout_q;
    delay_start_d = 1'b0;

    if (bus.clear) begin
      state_d   = S_IDLE;
      presc_d   = '0;
      bcd_d     = '0;
      cheat_d   = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start_btn) begin
            delay_start_d = 1'b1;
            bcd_d         = '0;
            cheat_d       = 1'b0;
            timeout_d     = 1'b0;
            state_d       = S_WAIT;
          end
        end
        S_WAIT: begin
          // A stop before the stimulus is a cheat, even alongside delay_complete.
          if (bus.stop_btn) begin
            bcd_d   = 16'h9999;
            cheat_d = 1'b1;
            state_d = S_DONE;
          end else if (bus.delay_complete) begin
            presc_d = '0;
            bcd_d   = '0;
            state_d = S_MEASURE;
          end
        end
        S_MEASURE: begin
          // Reaching the limit wins over a simultaneous stop; otherwise a stop
          // freezes the count and the coincident tick is discarded.
          if (ms_tick && inc_is_max) begin
            bcd_d     = bcd_inc;
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else if (bus.stop_btn) begin
            state_d = S_DONE;
          end else if (ms_tick) begin
            presc_d = '0;
            bcd_d   = bcd_inc;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    led_d = (state_d == S_MEASURE);
  end

  assign bus.delay_start = delay_start_q;
  assign bus.led         = led_q;
  assign bus.bcd3        = bcd_q[15:12];
  assign bus.bcd2        = bcd_q[11:8];
  assign bus.bcd1        = bcd_q[7:4];
  assign bus.bcd0        = bcd_q[3:0];
  assign bus.cheat       = cheat_q;
  assign bus.timeout     = timeout_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with CLK_PER_MS = 10, MAX_MS = 1000.
module tb_reaction_ctrl;

  localparam int W = 19;  // {bcd3, bcd2, bcd1, bcd0, cheat, timeout, led}

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [W-1:0] exp_q[$];

  reaction_ctrl_if bus ();

  reaction_ctrl #(
    .CLK_PER_MS (10),
    .MAX_MS     (1000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] result_now();
    return {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0, bus.cheat, bus.timeout, bus.led};
  endfunction

  function automatic logic [W-1:0] mk(input logic [15:0] bcd, input logic ch,
                                      input logic to, input logic l);
    return {bcd, ch, to, l};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; land 1 time unit after the last edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle pulse pattern on the input pulses.
  task automatic drive(input logic c, input logic s, input logic p, input logic d);
    bus.clear          = c;
    bus.start_btn      = s;
    bus.stop_btn       = p;
    bus.delay_complete = d;
    @(posedge clk);
    #1;
    bus.clear          = 1'b0;
    bus.start_btn      = 1'b0;
    bus.stop_btn       = 1'b0;
    bus.delay_complete = 1'b0;
  endtask

  // Scoreboard: wait (bounded) for a trial result, then compare with the queue head.
  task automatic check_result(input string tag, input int budget);
    logic [W-1:0] exp;
    int n;
    n = 0;
    while (bus.dbg_state !== ST_DONE && n < budget) begin
      wait_cycles(1);
      n++;
    end
    check({tag, "_done"}, 32'(bus.dbg_state), 32'(ST_DONE));
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      exp = exp_q.pop_front();
      check(tag, 32'(result_now()), 32'(exp));
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.clear          = 1'b0;
    bus.start_btn      = 1'b0;
    bus.stop_btn       = 1'b0;
    bus.delay_complete = 1'b0;
    wait_cycles(3);
    check("reset_result", 32'(result_now()), 32'(mk(16'h0000, 0, 0, 0)));
    check("reset_dstart", 32'(bus.delay_start), 32'd0);
    check("reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    wait_cycles(1);

    // Normal trial: stop 2375 cycles after delay_complete -> 0237
    drive(0, 1, 0, 0);
    check("t2_dstart_hi", 32'(bus.delay_start), 32'd1);
    check("t2_state_wait", 32'(bus.dbg_state), 32'(ST_WAIT));
    wait_cycles(1);
    check("t2_dstart_lo", 32'(bus.delay_start), 32'd0);
    wait_cycles(48);
    check("t2_led_wait", 32'(bus.led), 32'd0);
    exp_q.push_back(mk(16'h0237, 0, 0, 0));
    drive(0, 0, 0, 1);
    check("t2_led_on", 32'(bus.led), 32'd1);
    wait_cycles(2374);
    drive(0, 0, 1, 0);
    check_result("t2_result", 0);

    // Cheat: stop before delay_complete, late delay_complete ignored
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    wait_cycles(20);
    exp_q.push_back(mk(16'h9999, 1, 0, 0));
    drive(0, 0, 1, 0);
    check_result("t3_cheat", 0);
    drive(0, 0, 0, 1);
    wait_cycles(1);
    check("t3_late_dc", 32'(result_now()), 32'(mk(16'h9999, 1, 0, 0)));
    drive(1, 0, 0, 0);
    check("t3_clear", 32'(result_now()), 32'(mk(16'h0000, 0, 0, 0)));
    check("t3_clear_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Timeout: no stop, 0999 -> 1000 on the 1000th tick
    drive(0, 1, 0, 0);
    wait_cycles(5);
    drive(0, 0, 0, 1);
    wait_cycles(9999);
    check("t4_0999", 32'(result_now()), 32'(mk(16'h0999, 0, 0, 1)));
    exp_q.push_back(mk(16'h1000, 0, 1, 0));
    check_result("t4_timeout", 1);
    drive(0, 1, 0, 0);
    check("t4_start_in_done", 32'(bus.delay_start), 32'd0);
    wait_cycles(1);
    check("t4_hold", 32'(result_now()), 32'(mk(16'h1000, 0, 1, 0)));
    check("t4_hold_state", 32'(bus.dbg_state), 32'(ST_DONE));
    drive(1, 0, 0, 0);

    // Clear mid-measure at 0042; stale delay_complete ignored
    drive(0, 1, 0, 0);
    wait_cycles(3);
    drive(0, 0, 0, 1);
    wait_cycles(420);
    check("t5_0042", 32'(result_now()), 32'(mk(16'h0042, 0, 0, 1)));
    drive(1, 0, 0, 0);
    check("t5_clear", 32'(result_now()), 32'(mk(16'h0000, 0, 0, 0)));
    drive(0, 0, 0, 1);
    check("t5_stale_dc_led", 32'(bus.led), 32'd0);
    check("t5_stale_dc_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Clear beats start in IDLE
    drive(1, 1, 0, 0);
    check("clr_vs_start_ds", 32'(bus.delay_start), 32'd0);
    check("clr_vs_start_st", 32'(bus.dbg_state), 32'(ST_IDLE));

    // stop + delay_complete together in WAIT -> cheat
    drive(0, 1, 0, 0);
    wait_cycles(2);
    exp_q.push_back(mk(16'h9999, 1, 0, 0));
    drive(0, 0, 1, 1);
    check_result("t6_stop_dc", 0);
    drive(1, 0, 0, 0);

    // stop on the 5th ms tick -> 0004
    drive(0, 1, 0, 0);
    wait_cycles(2);
    drive(0, 0, 0, 1);
    wait_cycles(49);
    exp_q.push_back(mk(16'h0004, 0, 0, 0));
    drive(0, 0, 1, 0);
    check_result("t6_stop_tick", 0);
    drive(1, 0, 0, 0);

    // Reset mid-measure
    drive(0, 1, 0, 0);
    wait_cycles(2);
    drive(0, 0, 0, 1);
    wait_cycles(30);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("t1_reset_result", 32'(result_now()), 32'(mk(16'h0000, 0, 0, 0)));
    check("t1_reset_dstart", 32'(bus.delay_start), 32'd0);
    check("t1_reset_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    #2 reset = 1'b0;
    wait_cycles(1);

    // Reset while delay_start is high: no residual pulse
    drive(0, 1, 0, 0);
    check("t1b_dstart_hi", 32'(bus.delay_start), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t1b_dstart_killed", 32'(bus.delay_start), 32'd0);
    #2 reset = 1'b0;
    wait_cycles(1);
    check("t1b_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("t1b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
